seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Time-multiplexed 7-segment display scanner for the alarm-clock SoC. It consumes the 7-bit segment patterns from the per-digit Avalon PIO output ports (SEG0..SEGn). It drives a shared segment bus plus one-hot digit enables, with guard blanking against ghosting and tear-free frame-synchronous updates. It also provides per-digit blinking for alarm/time-set indication. It sits between the PIO `out_port` signals and the board pins.

## Interface
- `NUM_DIGITS`, 6: number of multiplexed digits (≥1)
- `DWELL_CYCLES`, 50000: clk cycles per digit slot (≥2)
- `GUARD_CYCLES`, 500: all-off cycles at the start of each slot (0 ≤ GUARD < DWELL)
- `BLINK_FRAMES`, 83: frames per blink half-period (≥1)
- `SEG_ACTIVE_LOW`, 1: segment output polarity
- `DIG_ACTIVE_LOW`, 1: digit enable polarity
- `clk` in 1: system clock
- `reset_n` in 1: reset, asynchronous, active-low
- `enable` in 1: scan enable; low forces display dark
- `seg_in` in 7*NUM_DIGITS: digit k at [7k+6:7k]; bit0=a … bit6=g; 1=lit
- `blink_mask` in NUM_DIGITS: 1 = digit blinks
- `seg_out` out 7: shared segment lines, polarity per `SEG_ACTIVE_LOW`
- `dig_sel` out NUM_DIGITS: one-hot digit enable, polarity per `DIG_ACTIVE_LOW`
- `frame_tick` out 1: one-cycle pulse per frame capture

## Operation
- Internal state:
  - prescaler `p`: 0..DWELL-1
  - digit index `idx`: 0..NUM_DIGITS-1
  - shadow copies of `seg_in`/`blink_mask`
  - blink counter `bc`: 0..BLINK_FRAMES-1
  - blink phase `ph`
- Counter behaviour when `enable`=1:
  - `p` increments each cycle.
  - At `p`=DWELL-1, `p`→0 and `idx` increments.
  - `idx` wraps from NUM_DIGITS-1 to 0.
- Capture condition is `p`=0 and `idx`=0. On a capture cycle:
  - The shadow registers load `seg_in`/`blink_mask`.
  - `frame_tick` asserts on the next cycle.
  - If `enable`=1, `bc` advances. When `bc` wraps from BLINK_FRAMES-1 to 0, `ph` toggles.
- Slot output:
  - When `p` < GUARD, all digits and segments are off.
  - Otherwise `dig_sel` selects `idx`, and `seg_out` shows shadow digit `idx`.
  - A digit is fully blanked (segments off, its `dig_sel` still active) when `ph`=1 and its shadow mask bit is 1.
- `enable`=0:
  - `p` and `idx` are held at 0, so the capture condition is true every cycle and the shadow reloads continuously.
  - `bc` and `ph` hold.
  - Outputs are off.
  - `frame_tick` pulses every cycle.
  - On re-enable, scanning starts at digit 0 with the current data.
- Widths:
  - `p` is clog2(DWELL_CYCLES).
  - `idx` is max(1, clog2(NUM_DIGITS)).
  - `bc` is max(1, clog2(BLINK_FRAMES)).
  - No arithmetic overflow; all wraps are explicit compares.
- "Off" means the inactive polarity level on every line.

## Timing
- Reset values:
  - `seg_out` = all inactive (7'h7F if SEG_ACTIVE_LOW, else 0).
  - `dig_sel` = all inactive.
  - `frame_tick` = 0.
  - `p`, `idx`, `bc`, `ph` and the shadow registers = 0.
- Reset is asynchronous; outputs go inactive immediately, mid-slot included.
- All outputs are registered and lag the internal counter state by exactly 1 cycle.
- The first cycle after reset release is a capture cycle, so no blank frame is shown with stale data.
- Each slot on the pins is GUARD all-off cycles followed by DWELL-GUARD cycles with exactly one digit active.
- No cycle ever has two digits active.
- Frame period is NUM_DIGITS×DWELL cycles.
- `seg_in` is sampled only on capture cycles. The value present on the capture cycle is the one used, even if it changes in that same cycle.
- Changes between captures are invisible until the next frame.
- `enable` falling: outputs go inactive on the next cycle.

## Structure
- Package `seg7_scan_pkg` holds:
  - segment bit index constants SEG_A..SEG_G (0..6)
  - `SEG_BLANK` = 7'h00
  - polarity apply function `apply_pol(value, active_low)`
- Sub-module `seg7_scan_timer` contains the prescaler, digit index and blink counter/phase. Its outputs are `idx`, `in_guard`, `capture` and `ph`.
- The top level holds the shadow registers, the output mux and the output registers.

## Test plan
All scenarios use NUM_DIGITS=4, DWELL=8, GUARD=2 and BLINK_FRAMES=2.

- Reset release, `seg_in`={7'h06,7'h5B,7'h4F,7'h66} (digits 3..0):
  - Each slot shows 2 off cycles then 6 cycles with the correct digit.
  - With active-low polarity, digit 0 shows `seg_out`=~7'h66 and `dig_sel`=4'b1110.
  - The frame repeats every 32 cycles, with `frame_tick` once per 32 cycles.
- Change `seg_in` mid-frame (during digit 1):
  - Digits 2–3 still show old values.
  - New values appear from the next frame's digit 0.
  - A change applied exactly on the capture cycle is taken.
- `blink_mask`=4'b0100:
  - Digit 2 is lit for 2 frames (64 cycles), then blank for 2 frames, while its `dig_sel` keeps cycling.
  - Other digits are unaffected.
- Drop `enable` during digit 2 for 10 cycles:
  - Outputs are inactive from the next cycle and `frame_tick` is continuously high.
  - On re-enable, digit 0 starts with a 2-cycle guard and current `seg_in`.
  - Blink phase is unchanged.
- Assert `reset_n` low asynchronously mid-slot (between clk edges):
  - Outputs go inactive immediately.
  - After release, the capture shows current data from digit 0.
- Over 10 frames, check every cycle:
  - Never more than one `dig_sel` line active.
  - `seg_out` is inactive whenever no digit is selected.

Source files
------------

// File: rtl/seg7_scan_pkg.sv
// rtl/seg7_scan_pkg.sv - shared constants and polarity helper for the 7-segment scanner
package seg7_scan_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] apply_pol(input logic [6:0] value, input logic active_low);
    return active_low ? ~value : value;
  endfunction

  // Counter width that never collapses to zero bits for single-value ranges.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// rtl/seg7_scan_timer.sv - slot prescaler, digit index and blink phase generator
module seg7_scan_timer
  import seg7_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int BLINK_FRAMES = 83,
  parameter int IDX_W        = width_min1(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [IDX_W-1:0] idx,
  output logic             in_guard,
  output logic             capture,
  output logic             ph
);

  localparam int P_W  = $clog2(DWELL_CYCLES);
  localparam int BC_W = width_min1(BLINK_FRAMES);

  localparam logic [P_W-1:0]   P_LAST   = P_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_FRAMES - 1);

  logic [P_W-1:0]  p;
  logic [BC_W-1:0] bc;
  logic            frame_start;

  assign frame_start = (p == '0) && (idx == '0);
  // While disabled the counters sit at zero, so every cycle is a capture.
  assign capture     = frame_start || !enable;

  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (p < P_W'(GUARD_CYCLES));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p   <= '0;
      idx <= '0;
    end else if (!enable) begin
      p   <= '0;
      idx <= '0;
    end else if (p == P_LAST) begin
      p   <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      p <= p + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bc <= '0;
      ph <= 1'b0;
    end else if (enable && frame_start) begin
      if (bc == BC_LAST) begin
        bc <= '0;
        ph <= ~ph;
      end else begin
        bc <= bc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - frame-synchronous multiplexed 7-segment display driver
module seg7_scan_mux
  import seg7_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int DWELL_CYCLES   = 50000,
  parameter int GUARD_CYCLES   = 500,
  parameter int BLINK_FRAMES   = 83,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);

  localparam int IDX_W = width_min1(NUM_DIGITS);
  localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_LOW = (DIG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_OFF = apply_pol(SEG_BLANK, SEG_LOW);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_LOW}};

  logic [IDX_W-1:0]        idx;
  logic                    in_guard;
  logic                    capture;
  logic                    ph;

  logic [7*NUM_DIGITS-1:0] seg_shadow;
  logic [NUM_DIGITS-1:0]   mask_shadow;
  logic [7*NUM_DIGITS-1:0] seg_frame;
  logic [NUM_DIGITS-1:0]   mask_frame;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   dig_next;

  seg7_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DWELL_CYCLES(DWELL_CYCLES),
    .GUARD_CYCLES(GUARD_CYCLES),
    .BLINK_FRAMES(BLINK_FRAMES),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .idx     (idx),
    .in_guard(in_guard),
    .capture (capture),
    .ph      (ph)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_shadow  <= '0;
      mask_shadow <= '0;
    end else if (capture) begin
      seg_shadow  <= seg_in;
      mask_shadow <= blink_mask;
    end
  end

  // Bypass on the capture cycle so a zero-guard slot 0 already shows the new frame.
  assign seg_frame  = capture ? seg_in     : seg_shadow;
  assign mask_frame = capture ? blink_mask : mask_shadow;

  always_comb begin
    seg_next = SEG_BLANK;
    dig_next = '0;
    if (enable && !in_guard) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx == IDX_W'(k)) begin
          dig_next[k] = 1'b1;
          seg_next    = (ph && mask_frame[k]) ? SEG_BLANK : seg_frame[7*k +: SEG_G + 1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out    <= SEG_OFF;
      dig_sel    <= DIG_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= apply_pol(seg_next, SEG_LOW);
      dig_sel    <= dig_next ^ DIG_OFF;
      frame_tick <= capture;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - directed self-checking bench for seg7_scan_mux
module tb_seg7_scan_mux;

  localparam logic [27:0] D1 = {7'h06, 7'h5B, 7'h4F, 7'h66};
  localparam logic [27:0] D2 = {7'h66, 7'h4F, 7'h5B, 7'h06};
  localparam logic [27:0] D3 = {7'h07, 7'h7D, 7'h6D, 7'h3F};

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [27:0] seg_in;
  logic [3:0]  blink_mask;
  logic [6:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference state: cycle within the scan, captured frame data, blink counter and phase.
  int          mc;
  logic [27:0] m_data;
  logic [3:0]  m_mask;
  int          m_bc;
  logic        m_ph;

  seg7_scan_mux #(
    .NUM_DIGITS    (4),
    .DWELL_CYCLES  (8),
    .GUARD_CYCLES  (2),
    .BLINK_FRAMES  (2),
    .SEG_ACTIVE_LOW(1),
    .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .seg_in    (seg_in),
    .blink_mask(blink_mask),
    .seg_out   (seg_out),
    .dig_sel   (dig_sel),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    mc     = 0;
    m_data = '0;
    m_mask = '0;
    m_bc   = 0;
    m_ph   = 1'b0;
  endtask

  task automatic run(input int n);
    logic [6:0] es;
    logic [3:0] ed;
    logic [3:0] one;
    logic       et;
    int         p;
    int         d;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!enable) begin
        es     = 7'h7F;
        ed     = 4'hF;
        et     = 1'b1;
        m_data = seg_in;
        m_mask = blink_mask;
        mc     = 0;
      end else begin
        p  = mc % 8;
        d  = (mc / 8) % 4;
        et = (mc % 32 == 0);
        if (et) begin
          m_data = seg_in;
          m_mask = blink_mask;
        end
        if (p < 2) begin
          es = 7'h7F;
          ed = 4'hF;
        end else begin
          one = 4'b0001 << d;
          ed  = ~one;
          es  = (m_ph && m_mask[d]) ? 7'h7F : ~m_data[7*d +: 7];
        end
        if (et) begin
          if (m_bc == 1) begin
            m_bc = 0;
            m_ph = ~m_ph;
          end else begin
            m_bc = m_bc + 1;
          end
        end
        mc++;
      end
      @(negedge clk);
      check("seg_out", 32'(seg_out), 32'(es));
      check("dig_sel", 32'(dig_sel), 32'(ed));
      check("frame_tick", 32'(frame_tick), 32'(et));
      check("one_hot", 32'($countones(~dig_sel) <= 1), 32'd1);
      if (dig_sel == 4'hF) check("seg_idle", 32'(seg_out), 32'h7F);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b1;
    seg_in     = D1;
    blink_mask = 4'b0000;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg_out), 32'h7F);
    check("rst_dig", 32'(dig_sel), 32'hF);
    check("rst_tick", 32'(frame_tick), 32'd0);
    reset_n = 1'b1;

    run(3);
    check("d0_seg", 32'(seg_out), 32'h19);
    check("d0_dig", 32'(dig_sel), 32'hE);
    run(61);

    run(11);
    seg_in = D2;
    run(53);
    seg_in     = D3;
    blink_mask = 4'b0100;
    run(1);
    run(49);
    run(1);
    check("blank_seg", 32'(seg_out), 32'h7F);
    check("blank_dig", 32'(dig_sel), 32'hB);
    run(109);

    run(20);
    enable = 1'b0;
    seg_in = D1;
    run(10);
    enable = 1'b1;
    run(3);
    check("reen_seg", 32'(seg_out), 32'h19);
    check("reen_dig", 32'(dig_sel), 32'hE);
    run(15);
    run(1);
    check("reen_blank_seg", 32'(seg_out), 32'h7F);
    check("reen_blank_dig", 32'(dig_sel), 32'hB);

    run(8);
    #2 reset_n = 1'b0;
    #1;
    check("async_seg", 32'(seg_out), 32'h7F);
    check("async_dig", 32'(dig_sel), 32'hF);
    check("async_tick", 32'(frame_tick), 32'd0);
    seg_in = D2;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    run(3);
    check("post_rst_seg", 32'(seg_out), 32'h79);
    check("post_rst_dig", 32'(dig_sel), 32'hE);
    run(317);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
